fsu_linear_ctrl: RTL and testbench

Sequencing controller for the FSU linear layer datapath. It takes a start request and drives weight load, accumulator clear, fold-part selection, per-fold accumulate hold and double-buffer bank select, so that every fold part accumulates one full bitstream. It then publishes the finished bank through a valid/ready handshake. It sits between the layer scheduler and one FSU linear instance and owns all of that instance's control inputs.

---
 rtl/fsu_ctrl_pkg.sv | 24 ++
 rtl/fsu_cycle_cnt.sv | 40 ++++
 rtl/fsu_linear_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_fsu_linear_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/fsu_ctrl_pkg.sv
// Shared types for the FSU linear-layer sequencing controller.
// Holds the controller state encoding and a job-length helper.
package fsu_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CLEAR,
        S_RUN,
        S_DRAIN,
        S_SWAP,
        S_WAIT
    } fsu_ctrl_state_t;

    // Cycles from the accepting edge through the edge that raises oValid.
    function automatic int unsigned job_len(
        input int unsigned fold,
        input int unsigned blen,
        input int unsigned lat
    );
        return 3 + fold * (blen + lat) + 1;
    endfunction

endpackage

// File: rtl/fsu_cycle_cnt.sv
// Loadable, clearable up-counter with a terminal-count flag.
module fsu_cycle_cnt #(
    parameter int CWID = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr_i,
    input  logic            ld_i,
    input  logic [CWID-1:0] ld_val_i,
    input  logic            en_i,
    input  logic [CWID-1:0] term_i,
    output logic [CWID-1:0] cnt_o,
    output logic            tc_o
);

    logic [CWID-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (ld_i) begin
            cnt_d = ld_val_i;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign tc_o  = (cnt_q == term_i);

endmodule

// File: rtl/fsu_linear_ctrl.sv
// FSU linear-layer sequencer: load, clear, per-fold run/drain, bank swap.
// Optional abort input enabled by FSU_LINEAR_CTRL_ABORT_EN.
module fsu_linear_ctrl
    import fsu_ctrl_pkg::*;
#(
    parameter int FOLD = 1,
    parameter int PWID = ($clog2(FOLD) < 2) ? 1 : $clog2(FOLD),
    parameter int BLEN = 1024,
    parameter int LAT  = 2,
    parameter int CWID = $clog2(BLEN + LAT + 1)
) (
    input  logic            clk,
    input  logic            rst,
`ifdef FSU_LINEAR_CTRL_ABORT_EN
    input  logic            abort,
`endif
    input  logic            start,
    input  logic            oReady,
    output logic            busy,
    output logic            load,
    output logic            clear,
    output logic [PWID-1:0] part,
    output logic [FOLD-1:0] hold,
    output logic            sel,
    output logic            oValid
);

    localparam logic [PWID-1:0] PLAST    = PWID'(FOLD - 1);
    localparam logic [CWID-1:0] RUN_LAST = CWID'(BLEN - 1);
    localparam logic [CWID-1:0] TERM     = CWID'(BLEN + LAT - 1);
    localparam bit              NO_DRAIN = (LAT == 0);

    fsu_ctrl_state_t state_q, state_d;
    logic [PWID-1:0] part_q, part_d;
    logic [FOLD-1:0] hold_q, hold_d;
    logic            sel_q, sel_d;
    logic            ovalid_q, ovalid_d;
    logic            busy_q, load_q, clear_q;

    logic            cnt_clr, cnt_ld, cnt_en, cnt_tc;
    logic [CWID-1:0] cnt;
    logic            part_end, do_swap, abort_w, abort_hit;

`ifdef FSU_LINEAR_CTRL_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    assign abort_hit = abort_w && (state_q inside
        {S_LOAD, S_CLEAR, S_RUN, S_DRAIN, S_WAIT});

    fsu_cycle_cnt #(.CWID(CWID)) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (cnt_clr),
        .ld_i     (cnt_ld),
        .ld_val_i ('0),
        .en_i     (cnt_en),
        .term_i   (TERM),
        .cnt_o    (cnt),
        .tc_o     (cnt_tc)
    );

    always_comb begin
        state_d  = state_q;
        part_d   = part_q;
        sel_d    = sel_q;
        ovalid_d = ovalid_q;
        cnt_clr  = 1'b0;
        cnt_ld   = 1'b0;
        cnt_en   = 1'b0;
        part_end = 1'b0;
        do_swap  = 1'b0;

        if (ovalid_q && oReady) begin
            ovalid_d = 1'b0;
        end

        if (abort_hit) begin
            state_d = S_IDLE;
            part_d  = '0;
            cnt_clr = 1'b1;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    cnt_clr = 1'b1;
                    if (start) state_d = S_LOAD;
                end
                S_LOAD: begin
                    cnt_clr = 1'b1;
                    part_d  = '0;
                    state_d = S_CLEAR;
                end
                S_CLEAR: begin
                    cnt_clr = 1'b1;
                    state_d = S_RUN;
                end
                S_RUN: begin
                    cnt_en = 1'b1;
                    if (cnt == RUN_LAST) begin
                        if (NO_DRAIN) part_end = 1'b1;
                        else          state_d  = S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    cnt_en = 1'b1;
                    if (cnt_tc) part_end = 1'b1;
                end
                S_SWAP: begin
                    cnt_clr = 1'b1;
                    if (!ovalid_q || oReady) do_swap = 1'b1;
                    else                     state_d = S_WAIT;
                end
                S_WAIT: begin
                    cnt_clr = 1'b1;
                    if (ovalid_q && oReady) do_swap = 1'b1;
                end
                default: state_d = S_IDLE;
            endcase

            if (part_end) begin
                cnt_ld = 1'b1;
                if (part_q != PLAST) begin
                    part_d  = part_q + 1'b1;
                    state_d = S_RUN;
                end else begin
                    state_d = S_SWAP;
                end
            end

            // A swap publishes the other bank, so oValid stays set.
            if (do_swap) begin
                sel_d    = ~sel_q;
                ovalid_d = 1'b1;
                state_d  = S_IDLE;
            end
        end
    end

    always_comb begin
        hold_d = '1;
        if (state_d == S_RUN || state_d == S_DRAIN) begin
            for (int i = 0; i < FOLD; i++) begin
                if (part_d == PWID'(i)) hold_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            part_q   <= '0;
            hold_q   <= '1;
            sel_q    <= 1'b0;
            ovalid_q <= 1'b0;
            busy_q   <= 1'b0;
            load_q   <= 1'b0;
            clear_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            part_q   <= part_d;
            hold_q   <= hold_d;
            sel_q    <= sel_d;
            ovalid_q <= ovalid_d;
            busy_q   <= (state_d != S_IDLE);
            load_q   <= (state_d == S_LOAD);
            clear_q  <= (state_d == S_CLEAR);
        end
    end

    assign busy   = busy_q;
    assign load   = load_q;
    assign clear  = clear_q;
    assign part   = part_q;
    assign hold   = hold_q;
    assign sel    = sel_q;
    assign oValid = ovalid_q;

endmodule

// File: tb/tb_fsu_linear_ctrl.sv
// Directed bench: FOLD=1 and FOLD=4 controllers, BLEN=8, LAT=2.
module tb_fsu_linear_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start1 = 1'b0, rdy1 = 1'b0, abort1 = 1'b0;
    logic       start4 = 1'b0, rdy4 = 1'b0, abort4 = 1'b0;
    logic       busy1, load1, clear1, sel1, ov1;
    logic [0:0] part1, hold1;
    logic       busy4, load4, clear4, sel4, ov4;
    logic [1:0] part4;
    logic [3:0] hold4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fsu_linear_ctrl #(.FOLD(1), .BLEN(8), .LAT(2)) u1 (
        .clk    (clk),
        .rst    (rst),
`ifdef FSU_LINEAR_CTRL_ABORT_EN
        .abort  (abort1),
`endif
        .start  (start1),
        .oReady (rdy1),
        .busy   (busy1),
        .load   (load1),
        .clear  (clear1),
        .part   (part1),
        .hold   (hold1),
        .sel    (sel1),
        .oValid (ov1)
    );

    fsu_linear_ctrl #(.FOLD(4), .BLEN(8), .LAT(2)) u4 (
        .clk    (clk),
        .rst    (rst),
`ifdef FSU_LINEAR_CTRL_ABORT_EN
        .abort  (abort4),
`endif
        .start  (start4),
        .oReady (rdy4),
        .busy   (busy4),
        .load   (load4),
        .clear  (clear4),
        .part   (part4),
        .hold   (hold4),
        .sel    (sel4),
        .oValid (ov4)
    );

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset1(input string tag);
        chk({tag, "_busy"},  32'(busy1),  0);
        chk({tag, "_load"},  32'(load1),  0);
        chk({tag, "_clear"}, 32'(clear1), 0);
        chk({tag, "_part"},  32'(part1),  0);
        chk({tag, "_hold"},  32'(hold1),  1);
        chk({tag, "_sel"},   32'(sel1),   0);
        chk({tag, "_ov"},    32'(ov1),    0);
    endtask

    initial begin
        int nload;

        tick(2);
        rst = 1'b0;
        chk_reset1("rst");
        chk("rst_hold4", 32'(hold4), 32'hf);

        // Single fold job, consumer always ready.
        rdy1 = 1'b1;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        chk("t1_load_c1", 32'(load1), 1);
        chk("t1_busy_c1", 32'(busy1), 1);
        tick();
        chk("t1_clear_c2", 32'(clear1), 1);
        chk("t1_load_c2", 32'(load1), 0);
        tick();
        for (int c = 3; c <= 12; c++) begin
            chk($sformatf("t1_hold_c%0d", c), 32'(hold1), 0);
            tick();
        end
        chk("t1_swap_hold", 32'(hold1), 1);
        chk("t1_swap_busy", 32'(busy1), 1);
        chk("t1_swap_sel", 32'(sel1), 0);
        chk("t1_swap_ov", 32'(ov1), 0);
        tick();
        chk("t1_e14_sel", 32'(sel1), 1);
        chk("t1_e14_ov", 32'(ov1), 1);
        chk("t1_e14_busy", 32'(busy1), 0);
        tick();
        chk("t1_e15_ov", 32'(ov1), 0);
        chk("t1_e15_sel", 32'(sel1), 1);

        // Four folds.
        rdy4 = 1'b1;
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        tick(2);
        for (int p = 0; p < 4; p++) begin
            for (int k = 0; k < 10; k++) begin
                chk($sformatf("t2_part_p%0d_k%0d", p, k), 32'(part4), p);
                chk($sformatf("t2_hold_p%0d_k%0d", p, k), 32'(hold4),
                    32'(~(4'b0001 << p) & 4'hf));
                tick();
            end
        end
        chk("t2_swap_hold", 32'(hold4), 32'hf);
        chk("t2_swap_ov", 32'(ov4), 0);
        tick();
        chk("t2_e44_ov", 32'(ov4), 1);
        chk("t2_e44_sel", 32'(sel4), 1);
        chk("t2_e44_part", 32'(part4), 3);

        // Back-to-back jobs with a stalled consumer.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rdy1 = 1'b0;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        tick(13);
        chk("t3_j1_sel", 32'(sel1), 1);
        chk("t3_j1_ov", 32'(ov1), 1);
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        tick(13);
        chk("t3_wait_busy", 32'(busy1), 1);
        chk("t3_wait_hold", 32'(hold1), 1);
        chk("t3_wait_sel", 32'(sel1), 1);
        chk("t3_wait_ov", 32'(ov1), 1);
        tick(3);
        chk("t3_wait2_busy", 32'(busy1), 1);
        rdy1 = 1'b1;
        tick();
        rdy1 = 1'b0;
        chk("t3_go_sel", 32'(sel1), 0);
        chk("t3_go_ov", 32'(ov1), 1);
        chk("t3_go_busy", 32'(busy1), 0);
        tick();
        chk("t3_after_sel", 32'(sel1), 0);

        // start held high for a whole job.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rdy1 = 1'b1;
        start1 = 1'b1;
        tick();
        nload = 0;
        for (int c = 1; c <= 13; c++) begin
            if (load1) nload++;
            tick();
        end
        chk("t4_nload", 32'(nload), 1);
        chk("t4_idle_busy", 32'(busy1), 0);
        tick();
        chk("t4_reload", 32'(load1), 1);
        start1 = 1'b0;
        tick(20);
        chk("t4_done_busy", 32'(busy1), 0);

        // Reset mid-RUN, then a fresh job.
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        tick(7);
        chk("t5_inrun_hold", 32'(hold1), 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_reset1("t5_rst");
        rdy1 = 1'b0;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        tick(13);
        chk("t5_ov", 32'(ov1), 1);
        chk("t5_sel", 32'(sel1), 1);
        chk("t5_busy", 32'(busy1), 0);

`ifdef FSU_LINEAR_CTRL_ABORT_EN
        // Abort during RUN with an unacknowledged result pending.
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        tick(6);
        chk("t6_run_busy", 32'(busy1), 1);
        abort1 = 1'b1;
        tick();
        abort1 = 1'b0;
        chk("t6_busy", 32'(busy1), 0);
        chk("t6_part", 32'(part1), 0);
        chk("t6_hold", 32'(hold1), 1);
        chk("t6_sel", 32'(sel1), 1);
        chk("t6_ov", 32'(ov1), 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
